// File: rtl/bram_tdp_if.sv
// Port bundle for the true dual-port block RAM: per-port enables, byte enables,
// address, write data and registered read data.
interface bram_tdp_if #(
    parameter int unsigned AWIDTH  = 10,
    parameter int unsigned DWIDTH  = 36,
    parameter int unsigned BEWIDTH = 4
);
    logic               rce_a;
    logic               wce_a;
    logic [BEWIDTH-1:0] be_a;
    logic [AWIDTH-1:0]  addr_a;
    logic [DWIDTH-1:0]  wd_a;
    logic [DWIDTH-1:0]  rq_a;

    logic               rce_b;
    logic               wce_b;
    logic [BEWIDTH-1:0] be_b;
    logic [AWIDTH-1:0]  addr_b;
    logic [DWIDTH-1:0]  wd_b;
    logic [DWIDTH-1:0]  rq_b;

    modport master (
        output rce_a, wce_a, be_a, addr_a, wd_a,
        output rce_b, wce_b, be_b, addr_b, wd_b,
        input  rq_a, rq_b
    );

    modport slave (
        input  rce_a, wce_a, be_a, addr_a, wd_a,
        input  rce_b, wce_b, be_b, addr_b, wd_b,
        output rq_a, rq_b
    );
endinterface

// File: rtl/bram_tdp_param.sv
// Parametrised true dual-port BRAM with byte enables, per-port write modes and a
// post-reset clear sweep. Define BRAM_TDP_OUTREG_EN for an extra output register.
module bram_tdp_param #(
    parameter int unsigned       AWIDTH   = 10,
    parameter int unsigned       DWIDTH   = 36,
    parameter int unsigned       BEWIDTH  = 4,
    parameter int unsigned       WMODE_A  = 0,
    parameter int unsigned       WMODE_B  = 0,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    output logic     init_busy,
    bram_tdp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam int unsigned LW    = DWIDTH / BEWIDTH;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                busy_d;
    logic                clr_c, run_c;
    logic [DWIDTH-1:0]   mem [DEPTH];
    logic [DWIDTH-1:0]   old_a, old_b, merged_a, merged_b;
    logic [DWIDTH-1:0]   rq1_a, rq1_b;

    // Next rq for one port given its write mode (0 write-first, 1 read-first, 2 no-change).
    function automatic logic [DWIDTH-1:0] next_rq(input int unsigned mode, input logic wce,
                                                  input logic rce, input logic [DWIDTH-1:0] old,
                                                  input logic [DWIDTH-1:0] merged,
                                                  input logic [DWIDTH-1:0] hold);
        next_rq = hold;
        if (wce) begin
            if (mode == 0) next_rq = merged;
            else if (mode == 1) next_rq = old;
        end else if (rce) begin
            next_rq = old;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_busy <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b1;
        clr_c   = 1'b0;
        run_c   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_c = 1'b1;
                cnt_d = cnt_q + AWIDTH'(1);
                if (&cnt_q) begin
                    state_d = S_RUN;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                run_c  = 1'b1;
                busy_d = 1'b0;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Pre-write words and own-port lane merges.
    always_comb begin
        old_a    = mem[bus.addr_a];
        old_b    = mem[bus.addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < BEWIDTH; i++) begin
            if (bus.be_a[i]) merged_a[i*LW +: LW] = bus.wd_a[i*LW +: LW];
            if (bus.be_b[i]) merged_b[i*LW +: LW] = bus.wd_b[i*LW +: LW];
        end
    end

    // Lane-wise writes; port A is applied last so it wins overlapping lanes.
    always_ff @(posedge clk) begin
        if (!rst && clr_c) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (!rst && run_c) begin
            for (int i = 0; i < BEWIDTH; i++) begin
                if (bus.wce_b && bus.be_b[i]) mem[bus.addr_b][i*LW +: LW] <= bus.wd_b[i*LW +: LW];
                if (bus.wce_a && bus.be_a[i]) mem[bus.addr_a][i*LW +: LW] <= bus.wd_a[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq1_a <= '0;
            rq1_b <= '0;
        end else if (run_c) begin
            rq1_a <= next_rq(WMODE_A, bus.wce_a, bus.rce_a, old_a, merged_a, rq1_a);
            rq1_b <= next_rq(WMODE_B, bus.wce_b, bus.rce_b, old_b, merged_b, rq1_b);
        end
    end

`ifdef BRAM_TDP_OUTREG_EN
    logic [DWIDTH-1:0] rq2_a, rq2_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            rq2_a <= '0;
            rq2_b <= '0;
        end else begin
            rq2_a <= rq1_a;
            rq2_b <= rq1_b;
        end
    end

    assign bus.rq_a = rq2_a;
    assign bus.rq_b = rq2_b;
`else
    assign bus.rq_a = rq1_a;
    assign bus.rq_b = rq1_b;
`endif
endmodule

// File: tb/tb_bram_tdp_param.sv
// Randomized self-checking bench for bram_tdp_param: two instances cover all
// three write modes and share one stimulus stream and one array-based model.
module tb_bram_tdp_param;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 36;
    localparam int unsigned BW    = 4;
    localparam int unsigned LW    = DW / BW;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [DW-1:0] INIT = 36'h5A;
`ifdef BRAM_TDP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    logic busy0, busy1;

    bram_tdp_if #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BW)) bus0 ();
    bram_tdp_if #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BW)) bus1 ();

    assign bus1.rce_a  = bus0.rce_a;
    assign bus1.wce_a  = bus0.wce_a;
    assign bus1.be_a   = bus0.be_a;
    assign bus1.addr_a = bus0.addr_a;
    assign bus1.wd_a   = bus0.wd_a;
    assign bus1.rce_b  = bus0.rce_b;
    assign bus1.wce_b  = bus0.wce_b;
    assign bus1.be_b   = bus0.be_b;
    assign bus1.addr_b = bus0.addr_b;
    assign bus1.wd_b   = bus0.wd_b;

    bram_tdp_param #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BW), .WMODE_A(0), .WMODE_B(1),
                     .INIT_VAL(INIT))
        u_dut0 (.clk(clk), .rst(rst), .init_busy(busy0), .bus(bus0));

    bram_tdp_param #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BW), .WMODE_A(1), .WMODE_B(2),
                     .INIT_VAL(INIT))
        u_dut1 (.clk(clk), .rst(rst), .init_busy(busy1), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: memory, sweep progress, and per-port stage-1/stage-2 outputs.
    logic [DW-1:0] mem_m [DEPTH];
    int            cnt_m;
    logic          busy_m;
    logic [DW-1:0] s1 [4];
    logic [DW-1:0] s2 [4];
    int unsigned   mode [4] = '{0, 1, 1, 2};
    string         tags [4] = '{"rq_u0a", "rq_u0b", "rq_u1a", "rq_u1b"};
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        merge = old;
        for (int i = 0; i < BW; i++)
            if (be[i]) merge[i*LW +: LW] = wd[i*LW +: LW];
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic set_a(input logic r, input logic w, input logic [BW-1:0] be,
                         input int addr, input logic [DW-1:0] wd);
        bus0.rce_a = r; bus0.wce_a = w; bus0.be_a = be; bus0.addr_a = AW'(addr); bus0.wd_a = wd;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [BW-1:0] be,
                         input int addr, input logic [DW-1:0] wd);
        bus0.rce_b = r; bus0.wce_b = w; bus0.be_b = be; bus0.addr_b = AW'(addr); bus0.wd_b = wd;
    endtask

    task automatic set_rand();
        set_a(1'($urandom), 1'($urandom), BW'($urandom), int'($urandom_range(0, DEPTH-1)), rnd_word());
        set_b(1'($urandom), 1'($urandom), BW'($urandom), int'($urandom_range(0, DEPTH-1)), rnd_word());
    endtask

    // Advance one clock: update the model from the current inputs, then compare after the edge.
    task automatic cycle(input logic r);
        logic [DW-1:0] oa, ob, ma, mb;
        logic [DW-1:0] obs [4];
        logic          w, rd;
        rst = r;
        if (r) begin
            for (int p = 0; p < 4; p++) begin s1[p] = '0; s2[p] = '0; end
            busy_m = 1'b1;
            cnt_m  = 0;
        end else begin
            for (int p = 0; p < 4; p++) s2[p] = s1[p];
            if (busy_m) begin
                mem_m[cnt_m] = INIT;
                cnt_m++;
                if (cnt_m == int'(DEPTH)) busy_m = 1'b0;
            end else begin
                oa = mem_m[bus0.addr_a];
                ob = mem_m[bus0.addr_b];
                ma = merge(oa, bus0.wd_a, bus0.be_a);
                mb = merge(ob, bus0.wd_b, bus0.be_b);
                for (int p = 0; p < 4; p++) begin
                    w  = ((p % 2) != 0) ? bus0.wce_b : bus0.wce_a;
                    rd = ((p % 2) != 0) ? bus0.rce_b : bus0.rce_a;
                    if (w) begin
                        if (mode[p] == 0) s1[p] = ((p % 2) != 0) ? mb : ma;
                        else if (mode[p] == 1) s1[p] = ((p % 2) != 0) ? ob : oa;
                    end else if (rd) begin
                        s1[p] = ((p % 2) != 0) ? ob : oa;
                    end
                end
                if (bus0.wce_b) mem_m[bus0.addr_b] = merge(mem_m[bus0.addr_b], bus0.wd_b, bus0.be_b);
                if (bus0.wce_a) mem_m[bus0.addr_a] = merge(mem_m[bus0.addr_a], bus0.wd_a, bus0.be_a);
            end
        end
        @(posedge clk);
        @(negedge clk);
        obs[0] = bus0.rq_a; obs[1] = bus0.rq_b; obs[2] = bus1.rq_a; obs[3] = bus1.rq_b;
        check("busy_u0", DW'(busy0), DW'(busy_m));
        check("busy_u1", DW'(busy1), DW'(busy_m));
        for (int p = 0; p < 4; p++)
            check(tags[p], obs[p], (LAT == 2) ? s2[p] : s1[p]);
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_a(1'b1, 1'b0, '0, i, '0);
            set_b(1'b1, 1'b0, '0, int'(DEPTH) - 1 - i, '0);
            cycle(1'b0);
        end
        set_a(1'b0, 1'b0, '0, 0, '0);
        set_b(1'b0, 1'b0, '0, 0, '0);
        repeat (2) cycle(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, '0, 0, '0);
        set_b(1'b0, 1'b0, '0, 0, '0);
        @(negedge clk);
        repeat (2) cycle(1'b1);

        // Full sweep with random commands that must be ignored, then read everything back.
        repeat (DEPTH) begin set_rand(); cycle(1'b0); end
        read_all();

        // Byte-enable write on a zeroed word, A at addr 3 and B at addr 4 together.
        set_a(1'b0, 1'b1, 4'hF, 3, '0);
        set_b(1'b0, 1'b1, 4'hF, 4, '0);
        cycle(1'b0);
        set_a(1'b0, 1'b1, 4'b0101, 3, {DW{1'b1}});
        set_b(1'b0, 1'b1, 4'b0101, 4, {DW{1'b1}});
        cycle(1'b0);
        set_a(1'b1, 1'b0, '0, 3, '0);
        set_b(1'b1, 1'b0, '0, 4, '0);
        cycle(1'b0);

        // Write with no lanes enabled.
        set_a(1'b0, 1'b1, 4'b0000, 3, rnd_word());
        set_b(1'b1, 1'b0, '0, 3, '0);
        cycle(1'b0);

        // Write/write collision on addr 7.
        set_a(1'b0, 1'b1, 4'b0011, 7, 36'h111111111);
        set_b(1'b0, 1'b1, 4'b0110, 7, 36'h222222222);
        cycle(1'b0);
        set_a(1'b1, 1'b0, '0, 7, '0);
        set_b(1'b1, 1'b0, '0, 7, '0);
        cycle(1'b0);

        // Cross-port read during write on addr 9.
        set_a(1'b0, 1'b1, 4'hF, 9, 36'hABC);
        set_b(1'b1, 1'b0, '0, 9, '0);
        cycle(1'b0);
        set_a(1'b0, 1'b0, '0, 0, '0);
        cycle(1'b0);

        // Random traffic with occasional resets in RUN.
        repeat (400) begin
            set_rand();
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        // Reset mid-sweep at address 5, then a full sweep under random commands.
        set_rand();
        cycle(1'b1);
        repeat (5) begin set_rand(); cycle(1'b0); end
        cycle(1'b1);
        repeat (DEPTH) begin set_rand(); cycle(1'b0); end
        read_all();

        // Distinct data then back-to-back reads of 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b0, 1'b1, 4'hF, i, rnd_word());
            set_b(1'b0, 1'b0, '0, 0, '0);
            cycle(1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, '0, i, '0);
            cycle(1'b0);
        end
        set_a(1'b0, 1'b0, '0, 0, '0);
        repeat (3) cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
